// File: rtl/xadc_sim_pkg.sv
// Shared types and constants for the XADC behavioural model.
// Pure declarations: no logic, no latency.
// Not applicable: holds no flow-controlled interfaces.
package xadc_sim_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_CONV = 2'd2
    } xadc_state_e;

    localparam logic [6:0] ADDR_VPVN    = 7'h03;
    localparam logic [6:0] ADDR_CFG0    = 7'h40;
    localparam logic [6:0] ADDR_CFG1    = 7'h41;
    localparam logic [6:0] ADDR_CFG2    = 7'h42;

    localparam logic [4:0] CHANNEL_VPVN = 5'd3;

    // Cycles from the DEN edge to the DRDY edge.
    localparam int         DRP_LATENCY  = 2;

    // Index of the last sub-sample for an averaging select (N-1 for N = 1/4/16/64).
    function automatic logic [5:0] avg_last_idx(input logic [1:0] sel);
        logic [5:0] idx;
        idx = 6'd0;
        case (sel)
            2'b00:   idx = 6'd0;
            2'b01:   idx = 6'd3;
            2'b10:   idx = 6'd15;
            default: idx = 6'd63;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/xadc_drp_regs.sv
// DRP register file (result reg 0x03, config/user regs 0x40-0x7F) with read/write pipeline.
// Latency: DRDY pulses DRP_LATENCY cycles after the accepted DEN edge; DO valid with DRDY.
// Backpressure: none; a DEN arriving while an op is in flight is dropped, not queued.
module xadc_drp_regs #(
    parameter logic [15:0] INIT_40 = 16'h8203,
    parameter logic [15:0] INIT_41 = 16'h313F,
    parameter logic [15:0] INIT_42 = 16'h0A00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        den_i,
    input  logic        dwe_i,
    input  logic [6:0]  daddr_i,
    input  logic [15:0] di_i,
    input  logic        res_wr_i,
    input  logic [15:0] res_dat_i,
`ifdef XADC_AVG_EN
    output logic [1:0]  avg_sel_o,
`endif
    output logic [15:0] do_o,
    output logic        drdy_o
);
    import xadc_sim_pkg::*;

    logic [15:0]            res_q;
    logic [15:0]            hi_q [64];
    logic [DRP_LATENCY-1:0] vld_q;
    logic                   op_we_q;
    logic [15:0]            op_rd_q;
    logic                   drdy_q;
    logic [15:0]            do_q;

    logic                   accept;
    logic                   wr_hi;
    logic [15:0]            rd_val;

    assign accept = den_i && !(|vld_q);
    // Only the upper half of the address space is writable; 0x03 is owned by the converter.
    assign wr_hi  = accept && dwe_i && daddr_i[6];

    // Read mux: value of the addressed register before any same-edge write lands.
    always_comb begin
        rd_val = 16'h0000;
        if (daddr_i == ADDR_VPVN) begin
            rd_val = res_q;
        end else if (daddr_i[6]) begin
            rd_val = hi_q[daddr_i[5:0]];
        end
    end

    // Register storage: converter result and the 0x40-0x7F block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q <= 16'h0000;
            for (int i = 0; i < 64; i++) begin
                hi_q[i] <= 16'h0000;
            end
            hi_q[ADDR_CFG0[5:0]] <= INIT_40;
            hi_q[ADDR_CFG1[5:0]] <= INIT_41;
            hi_q[ADDR_CFG2[5:0]] <= INIT_42;
        end else begin
            if (res_wr_i) begin
                res_q <= res_dat_i;
            end
            if (wr_hi) begin
                hi_q[daddr_i[5:0]] <= di_i;
            end
        end
    end

    // Op pipeline: capture read data at DEN, release it with DRDY at the end of the shift.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            op_we_q <= 1'b0;
            op_rd_q <= 16'h0000;
            drdy_q  <= 1'b0;
            do_q    <= 16'h0000;
        end else begin
            vld_q  <= (vld_q << 1) | DRP_LATENCY'(accept);
            drdy_q <= vld_q[DRP_LATENCY-1];
            if (accept) begin
                op_we_q <= dwe_i;
                op_rd_q <= rd_val;
            end
            if (vld_q[DRP_LATENCY-1] && !op_we_q) begin
                do_q <= op_rd_q;
            end
        end
    end

`ifdef XADC_AVG_EN
    assign avg_sel_o = hi_q[ADDR_CFG0[5:0]][13:12];
`endif
    assign do_o   = do_q;
    assign drdy_o = drdy_q;

endmodule

// File: rtl/xadc_sim_model.sv
// Behavioural XADC, event-driven single channel (VP/VN): boot calibration, CONVST conversions, DRP port.
// Latency: EOC/EOS CONV_CYCLES (x N sub-samples with XADC_AVG_EN) after the CONVST edge; DRDY 2 cycles after DEN.
// Backpressure: none; CONVST edges while BUSY and DEN while a DRP op is pending are ignored.
// Optional build macro XADC_AVG_EN enables sample averaging selected by reg 0x40[13:12].
module xadc_sim_model #(
    parameter logic [15:0] INIT_40     = 16'h8203,
    parameter logic [15:0] INIT_41     = 16'h313F,
    parameter logic [15:0] INIT_42     = 16'h0A00,
    parameter int          BOOT_CYCLES = 64,
    parameter int          CONV_CYCLES = 26
) (
    input  logic        DCLK,
    input  logic        RESET,
    input  logic        CONVST,
    input  logic        DEN,
    input  logic        DWE,
    input  logic [6:0]  DADDR,
    input  logic [15:0] DI,
    input  logic [11:0] VP_CODE,
    output logic        BUSY,
    output logic        EOC,
    output logic        EOS,
    output logic [4:0]  CHANNEL,
    output logic [15:0] DO,
    output logic        DRDY
);
    import xadc_sim_pkg::*;

    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int SW = $clog2(CONV_CYCLES + 1);

    xadc_state_e   state_q, state_d;
    logic [BW-1:0] boot_cnt_q;
    logic [SW-1:0] sub_cnt_q;
    logic          convst_q;
    logic [4:0]    channel_q;

`ifdef XADC_AVG_EN
    logic [17:0]   acc_q;
    logic [5:0]    samp_q;
    logic [5:0]    samp_last_q;
    logic [1:0]    avg_sel_q;
    logic [1:0]    avg_sel;
`else
    logic [11:0]   acc_q;
`endif

    logic          convst_rise;
    logic          boot_done;
    logic          sub_end;
    logic          last_samp;
    logic          conv_done;
    logic          busy;
    logic          eoc;
    logic [15:0]   res_dat;

    assign convst_rise = CONVST && !convst_q;
    assign boot_done   = (boot_cnt_q == BW'(BOOT_CYCLES - 1));
    // Last cycle of the current sub-conversion (sample boundary when averaging).
    assign sub_end     = (sub_cnt_q == SW'(CONV_CYCLES - 1));
`ifdef XADC_AVG_EN
    assign last_samp   = (samp_q == samp_last_q);
`else
    assign last_samp   = 1'b1;
`endif
    // The counter reaches CONV_CYCLES only in the EOC cycle of the final sub-conversion.
    assign conv_done   = last_samp && (sub_cnt_q == SW'(CONV_CYCLES));

    // State register.
    always_ff @(posedge DCLK) begin
        if (RESET) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: if (boot_done)   state_d = ST_IDLE;
            ST_IDLE: if (convst_rise) state_d = ST_CONV;
            ST_CONV: if (conv_done)   state_d = ST_IDLE;
            default:                  state_d = ST_BOOT;
        endcase
    end

    // Status outputs decoded from state; EOC spans the final counted cycle of CONV.
    always_comb begin
        busy = 1'b1;
        eoc  = 1'b0;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_CONV: eoc  = conv_done;
            default: busy = 1'b1;
        endcase
    end

    // Counters, track/hold capture, accumulation and channel tag.
    always_ff @(posedge DCLK) begin
        if (RESET) begin
            boot_cnt_q  <= '0;
            sub_cnt_q   <= '0;
            convst_q    <= 1'b0;
            channel_q   <= 5'd0;
            acc_q       <= '0;
`ifdef XADC_AVG_EN
            samp_q      <= 6'd0;
            samp_last_q <= 6'd0;
            avg_sel_q   <= 2'b00;
`endif
        end else begin
            convst_q <= CONVST;
            if (state_q == ST_BOOT && !boot_done) begin
                boot_cnt_q <= boot_cnt_q + BW'(1);
            end
            if (state_q == ST_IDLE && convst_rise) begin
                sub_cnt_q   <= '0;
`ifdef XADC_AVG_EN
                acc_q       <= 18'(VP_CODE);
                samp_q      <= 6'd0;
                samp_last_q <= avg_last_idx(avg_sel);
                avg_sel_q   <= avg_sel;
`else
                acc_q       <= VP_CODE;
`endif
            end else if (state_q == ST_CONV && !conv_done) begin
`ifdef XADC_AVG_EN
                if (sub_end && !last_samp) begin
                    sub_cnt_q <= '0;
                    samp_q    <= samp_q + 6'd1;
                    acc_q     <= acc_q + 18'(VP_CODE);
                end else begin
                    sub_cnt_q <= sub_cnt_q + SW'(1);
                end
`else
                sub_cnt_q <= sub_cnt_q + SW'(1);
`endif
                // Lands together with EOC rising.
                if (sub_end && last_samp) begin
                    channel_q <= CHANNEL_VPVN;
                end
            end
        end
    end

    // Result word: code in [15:4], averaged by truncating shift when enabled.
    always_comb begin
        res_dat = 16'h0000;
`ifdef XADC_AVG_EN
        case (avg_sel_q)
            2'b00:   res_dat = {acc_q[11:0], 4'h0};
            2'b01:   res_dat = {acc_q[13:2], 4'h0};
            2'b10:   res_dat = {acc_q[15:4], 4'h0};
            default: res_dat = {acc_q[17:6], 4'h0};
        endcase
`else
        res_dat = {acc_q, 4'h0};
`endif
    end

    // Result is committed at the edge ending the EOC cycle, so a read sampled there sees the old value.
    xadc_drp_regs #(
        .INIT_40 (INIT_40),
        .INIT_41 (INIT_41),
        .INIT_42 (INIT_42)
    ) u_drp_regs (
        .clk_i     (DCLK),
        .rst_i     (RESET),
        .den_i     (DEN),
        .dwe_i     (DWE),
        .daddr_i   (DADDR),
        .di_i      (DI),
        .res_wr_i  (eoc),
        .res_dat_i (res_dat),
`ifdef XADC_AVG_EN
        .avg_sel_o (avg_sel),
`endif
        .do_o      (DO),
        .drdy_o    (DRDY)
    );

    assign BUSY    = busy;
    assign EOC     = eoc;
    assign EOS     = eoc;
    assign CHANNEL = channel_q;

endmodule

// File: tb/tb_xadc_sim_model.sv
// Self-checking bench for xadc_sim_model: DRP scoreboard plus conversion timing checks.
// DRP expectations are queued at DEN time and popped on DRDY.
// Averaging scenario is included when XADC_AVG_EN is defined.
module tb_xadc_sim_model;

    logic        DCLK    = 1'b0;
    logic        RESET   = 1'b1;
    logic        CONVST  = 1'b0;
    logic        DEN     = 1'b0;
    logic        DWE     = 1'b0;
    logic [6:0]  DADDR   = 7'h00;
    logic [15:0] DI      = 16'h0000;
    logic [11:0] VP_CODE = 12'h000;
    logic        BUSY;
    logic        EOC;
    logic        EOS;
    logic [4:0]  CHANNEL;
    logic [15:0] DO;
    logic        DRDY;

    xadc_sim_model dut (
        .DCLK    (DCLK),
        .RESET   (RESET),
        .CONVST  (CONVST),
        .DEN     (DEN),
        .DWE     (DWE),
        .DADDR   (DADDR),
        .DI      (DI),
        .VP_CODE (VP_CODE),
        .BUSY    (BUSY),
        .EOC     (EOC),
        .EOS     (EOS),
        .CHANNEL (CHANNEL),
        .DO      (DO),
        .DRDY    (DRDY)
    );

    always #5 DCLK = ~DCLK;

    int cyc = 0;
    always @(posedge DCLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] dat;
        logic [31:0] due;
    } sb_t;

    sb_t         sb_q [$];
    logic [15:0] mdl [128];
    logic [15:0] mdl_do;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 128; i++) mdl[i] = 16'h0000;
        mdl[7'h40] = 16'h8203;
        mdl[7'h41] = 16'h313F;
        mdl[7'h42] = 16'h0A00;
        mdl_do     = 16'h0000;
    endtask

    // Drive DEN for the coming edge and queue what DRDY must bring back.
    task automatic drp_issue(input logic we, input logic [6:0] a, input logic [15:0] d);
        sb_t e;
        if (we) begin
            if (a[6]) mdl[a] = d;
        end else begin
            mdl_do = mdl[a];
        end
        e.dat = mdl_do;
        e.due = 32'(cyc + 3);
        sb_q.push_back(e);
        DEN   = 1'b1;
        DWE   = we;
        DADDR = a;
        DI    = d;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge DCLK); #1;
        end
        if (sb_q.size() > 0) begin
            chk("sb_timeout", 32'(sb_q.size()), 0);
            sb_q.delete();
        end
    endtask

    task automatic drp_op(input logic we, input logic [6:0] a, input logic [15:0] d);
        drp_issue(we, a, d);
        @(posedge DCLK); #1;
        DEN = 1'b0;
        DWE = 1'b0;
        wait_sb();
    endtask

    task automatic boot_wait(output int n_busy, output int n_eoc);
        n_busy = 0;
        n_eoc  = 0;
        while (BUSY === 1'b1 && n_busy < 300) begin
            n_busy++;
            if (EOC === 1'b1) n_eoc++;
            @(posedge DCLK); #1;
        end
    endtask

    // One CONVST conversion; optional re-pulse, per-sub-sample code toggling, read in the EOC cycle.
    task automatic conv_run(input logic [11:0] code, input bit repulse, input bit alt,
                            input bit rd_on_eoc, input int lat, input logic [15:0] exp_res);
        int n_eoc;
        int eoc_at;
        n_eoc   = 0;
        eoc_at  = -1;
        VP_CODE = code;
        CONVST  = 1'b1;
        @(posedge DCLK); #1;
        CONVST = 1'b0;
        chk("busy_rise", BUSY, 1);
        for (int k = 1; k <= lat + 5; k++) begin
            if (repulse && k == 10) begin
                CONVST  = 1'b1;
                VP_CODE = 12'h111;
            end
            if (repulse && k == 11) CONVST = 1'b0;
            if (alt && (k % 26) == 0 && k < lat) VP_CODE = ((k / 26) % 2 == 1) ? 12'h104 : 12'h100;
            if (rd_on_eoc && k == lat + 1) drp_issue(1'b0, 7'h03, 16'h0000);
            if (rd_on_eoc && k == lat + 2) DEN = 1'b0;
            @(posedge DCLK); #1;
            if (EOC === 1'b1) begin
                n_eoc++;
                if (eoc_at < 0) eoc_at = k;
                chk("eos_with_eoc", EOS, 1);
                chk("channel", CHANNEL, 3);
            end
            if (k == lat)     chk("busy_in_eoc", BUSY, 1);
            if (k == lat + 1) chk("busy_after_eoc", BUSY, 0);
        end
        chk("eoc_count", n_eoc, 1);
        chk("eoc_latency", eoc_at, lat);
        mdl[7'h03] = exp_res;
        wait_sb();
        drp_op(1'b0, 7'h03, 16'h0000);
    endtask

    // DRDY monitor: every pulse must match the oldest queued op, on time.
    always @(negedge DCLK) begin
        sb_t e;
        if (DRDY === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("drdy_unexpected", 32'(DRDY), 0);
            end else begin
                e = sb_q.pop_front();
                chk("drp_do", DO, e.dat);
                chk("drdy_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=%0d exp=done", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        int n_eoc;
        mdl_reset();
        repeat (3) @(posedge DCLK);
        #1;
        chk("rst_busy", BUSY, 1);
        chk("rst_eoc", EOC, 0);
        chk("rst_eos", EOS, 0);
        chk("rst_drdy", DRDY, 0);
        chk("rst_do", DO, 0);
        chk("rst_channel", CHANNEL, 0);
        RESET = 1'b0;
        boot_wait(n_busy, n_eoc);
        chk("boot_len", n_busy, 64);
        chk("boot_eoc", n_eoc, 0);
        drp_op(1'b0, 7'h40, 16'h0000);

        // Conversion with a mid-flight CONVST that must be ignored; read 0x03 in the EOC cycle.
        conv_run(12'h5A3, 1'b1, 1'b0, 1'b1, 26, 16'h5A30);

        // Register writes, dropped low-half write, back-to-back DEN.
        drp_op(1'b1, 7'h41, 16'hABCD);
        drp_op(1'b0, 7'h41, 16'h0000);
        drp_op(1'b1, 7'h03, 16'hFFFF);
        drp_op(1'b0, 7'h03, 16'h0000);
        drp_op(1'b0, 7'h55, 16'h0000);
        drp_issue(1'b0, 7'h42, 16'h0000);
        @(posedge DCLK); #1;
        DADDR = 7'h41;
        @(posedge DCLK); #1;
        DEN = 1'b0;
        wait_sb();
        repeat (4) @(posedge DCLK);
        #1;
        chk("do_hold", DO, mdl_do);

        // Reset during a conversion aborts it and restarts boot.
        VP_CODE = 12'h777;
        CONVST  = 1'b1;
        @(posedge DCLK); #1;
        CONVST = 1'b0;
        n_eoc  = 0;
        for (int k = 1; k < 10; k++) begin
            @(posedge DCLK); #1;
            if (EOC === 1'b1) n_eoc++;
        end
        RESET = 1'b1;
        @(posedge DCLK); #1;
        RESET = 1'b0;
        mdl_reset();
        chk("abort_busy", BUSY, 1);
        chk("abort_do", DO, 0);
        chk("abort_channel", CHANNEL, 0);
        boot_wait(n_busy, n_busy == 0 ? n_eoc : n_eoc);
        chk("reboot_len", n_busy, 64);
        chk("abort_no_eoc", n_eoc, 0);
        drp_op(1'b0, 7'h03, 16'h0000);

`ifdef XADC_AVG_EN
        // Four-sample average of alternating codes.
        drp_op(1'b1, 7'h40, 16'h9203);
        conv_run(12'h100, 1'b0, 1'b1, 1'b0, 104, 16'h1020);
`endif

        repeat (4) @(posedge DCLK);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
